// File: rtl/alu_pkg.sv
// alu_pkg: opcode values, FSM encoding and default width shared by the ALU control decoder and execution unit.
package alu_pkg;
    localparam int WIDTH_DEF = 32;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_MULT = 2'd1, S_DONE = 2'd2} state_t;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative unsigned shift-add multiplier, one partial product per cycle.
module alu_mul_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               mul_done
);
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;
    logic [CNT_W-1:0]   cnt;
    logic               running;
    logic [WIDTH:0]     sum;
    // The multiplier shares the low half of the accumulator and is consumed as the product shifts in.
    assign sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, acc[0] ? mcand : '0};
    assign product  = {sum, acc[WIDTH-1:1]};
    assign mul_done = running && cnt == CNT_W'(WIDTH - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            mcand   <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (load) begin
            acc     <= {{WIDTH{1'b0}}, b};
            mcand   <= a;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            acc     <= product;
            cnt     <= cnt + 1'b1;
            running <= !mul_done;
        end
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-cycle ADD/SUB/AND/OR and multi-cycle MUL behind a start/busy/done handshake.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ctrl_command,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow,
    output logic             illegal
);
    state_t             state, state_n;
    logic [WIDTH-1:0]   sum, diff, alu_res;
    logic               alu_ovf, alu_ill, is_mul, accept, mul_done;
    logic [2*WIDTH-1:0] product;
    assign ready  = state == S_IDLE;
    assign busy   = state == S_MULT;
    assign done   = state == S_DONE;
    assign is_mul = ctrl_command == OP_MUL;
    assign accept = ready && start;
    always_comb begin
        sum     = operand_a + operand_b;
        diff    = operand_a - operand_b;
        alu_ill = ctrl_command > OP_OR;
        alu_res = ctrl_command == OP_ADD ? sum :
                  ctrl_command == OP_SUB ? diff :
                  ctrl_command == OP_AND ? operand_a & operand_b :
                  ctrl_command == OP_OR  ? operand_a | operand_b : '0;
        alu_ovf = ctrl_command == OP_ADD ? (operand_a[WIDTH-1] == operand_b[WIDTH-1]) && (sum[WIDTH-1] != operand_a[WIDTH-1]) :
                  ctrl_command == OP_SUB ? (operand_a[WIDTH-1] != operand_b[WIDTH-1]) && (diff[WIDTH-1] != operand_a[WIDTH-1]) : 1'b0;
    end
    alu_mul_seq #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
        .clk      (clk),
        .rst      (rst),
        .load     (accept && is_mul),
        .a        (operand_a),
        .b        (operand_b),
        .product  (product),
        .mul_done (mul_done)
    );
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = start ? (is_mul ? S_MULT : S_DONE) : S_IDLE;
            S_MULT:  state_n = mul_done ? S_DONE : S_MULT;
            default: state_n = S_IDLE;
        endcase
    end
    // Outputs hold between completions; a multiply only publishes on its final iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            result    <= '0;
            result_hi <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
        end else if (accept && !is_mul) begin
            result    <= alu_res;
            result_hi <= '0;
            zero      <= alu_res == '0;
            overflow  <= alu_ovf;
            illegal   <= alu_ill;
        end else if (busy && mul_done) begin
            {result_hi, result} <= product;
            zero      <= product[WIDTH-1:0] == '0;
            overflow  <= product[2*WIDTH-1:WIDTH] != '0;
            illegal   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors checked against a cycle-level behavioural model plus literal expectations.
module tb_alu_exec_unit;
    localparam int W = 32;
    logic         clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [3:0]   cmd = '0;
    logic [W-1:0] a = '0, b = '0;
    logic         ready, busy, done, zero, overflow, illegal;
    logic [W-1:0] result, result_hi;
    int           n_chk = 0, n_fail = 0;
    bit           chk_en = 0;

    alu_exec_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .ctrl_command(cmd),
        .operand_a(a), .operand_b(b), .ready(ready), .busy(busy), .done(done),
        .result(result), .result_hi(result_hi), .zero(zero), .overflow(overflow), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted op either completes next cycle or, for MUL, W cycles later.
    int           m_left = 0;
    bit           m_done = 0, m_zero = 0, m_ovf = 0, m_ill = 0;
    logic [W-1:0] m_res = '0, m_hi = '0;
    logic [63:0]  m_prod = '0;
    longint       sa, sb, s;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0; m_done = 0; m_res = '0; m_hi = '0; m_zero = 0; m_ovf = 0; m_ill = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_res = m_prod[31:0]; m_hi = m_prod[63:32];
                m_zero = (m_res == 0); m_ovf = (m_hi != 0); m_ill = 0; m_done = 1;
            end
        end else if (start) begin
            if (cmd == 4'd2) begin
                m_prod = 64'(a) * 64'(b);
                m_left = W;
            end else begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                m_hi = '0; m_ovf = 0; m_ill = 0;
                case (cmd)
                    4'd0: begin s = sa + sb; m_res = W'(s); m_ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
                    4'd1: begin s = sa - sb; m_res = W'(s); m_ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
                    4'd3: m_res = a & b;
                    4'd4: m_res = a | b;
                    default: begin m_res = '0; m_ill = 1; end
                endcase
                m_zero = (m_res == 0);
                m_done = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", ready, 64'(!m_done && m_left == 0));
            check("busy", busy, 64'(m_left > 0));
            check("done", done, 64'(m_done));
            check("result", result, 64'(m_res));
            check("result_hi", result_hi, 64'(m_hi));
            check("zero", zero, 64'(m_zero));
            check("overflow", overflow, 64'(m_ovf));
            check("illegal", illegal, 64'(m_ill));
        end
    end

    task automatic issue(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
        int g = 0;
        while (!ready && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (!ready) check("issue_timeout", 0, 1);
        cmd = c; a = x; b = y; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int nbusy);
        lat = 0; nbusy = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) nbusy++;
        end while (!done && lat < 100);
        if (!done) check("done_timeout", 0, 1);
    endtask

    int lat, nbusy, pulses;

    initial begin
        @(posedge clk); #1;
        chk_en = 1;
        @(posedge clk); #1;
        check("rst_ready", ready, 1);
        check("rst_result", result, 0);
        rst = 1'b0;

        issue(4'd0, 32'h7FFF_FFFF, 32'd1);
        wait_done(lat, nbusy);
        check("add_lat", lat, 1);
        check("add_res", result, 32'h8000_0000);
        check("add_ovf", overflow, 1);
        check("add_zero", zero, 0);

        issue(4'd1, 32'd5, 32'd5);
        wait_done(lat, nbusy);
        check("sub_res", result, 0);
        check("sub_zero", zero, 1);
        check("sub_ovf", overflow, 0);

        issue(4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00);
        wait_done(lat, nbusy);
        check("and_res", result, 32'hF000_F000);

        issue(4'd2, 32'hFFFF_FFFF, 32'd2);
        a = 32'd0; b = 32'd0;
        wait_done(lat, nbusy);
        check("mul_lat", lat, 33);
        check("mul_busy", nbusy, 32);
        check("mul_res", result, 32'hFFFF_FFFE);
        check("mul_hi", result_hi, 1);
        check("mul_ovf", overflow, 1);

        issue(4'd2, 32'd6, 32'd7);
        repeat (3) @(posedge clk);
        #1;
        cmd = 4'd0; a = 32'd100; b = 32'd100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat, nbusy);
        check("mul67_res", result, 42);
        check("mul67_hi", result_hi, 0);
        check("mul67_ovf", overflow, 0);

        issue(4'd9, 32'd123, 32'd456);
        wait_done(lat, nbusy);
        check("ill_lat", lat, 1);
        check("ill_res", result, 0);
        check("ill_flag", illegal, 1);
        check("ill_zero", zero, 1);

        issue(4'd4, 32'd1, 32'd2);
        wait_done(lat, nbusy);
        check("or_res", result, 3);
        check("or_ill", illegal, 0);

        issue(4'd2, 32'h1234_5678, 32'h9ABC_DEF0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", ready, 1);
        check("abort_busy", busy, 0);
        check("abort_res", result, 0);
        check("abort_hi", result_hi, 0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0);

        issue(4'd0, 32'd2, 32'd3);
        wait_done(lat, nbusy);
        check("post_add", result, 5);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execution stage directly downstream of the ALU control decoder; consumes its 4-bit ctrl_command plus two register operands and produces the result and flags.
- ADD/SUB/AND/OR complete in one cycle; MUL uses an iterative shift-add multiplier over WIDTH cycles.
- Uses a start/busy/done handshake so the datapath sequencer can stall on multi-cycle operations.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, width of the multiply iteration counter; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin an operation; sampled only in IDLE.
- ctrl_command  input  4  operation code: 0=ADD, 1=SUB, 2=MUL, 3=AND, 4=OR; 5..15 are illegal.
- operand_a  input  WIDTH  first operand, captured when start is accepted.
- operand_b  input  WIDTH  second operand, captured when start is accepted.
- ready  output  1  high in IDLE; start is accepted only when ready=1.
- busy  output  1  high while in MULT.
- done  output  1  one-cycle pulse when the result is valid.
- result  output  WIDTH  low word of the result.
- result_hi  output  WIDTH  upper word of the MUL product; 0 for all other operations.
- zero  output  1  result == 0.
- overflow  output  1  ADD/SUB: signed overflow. MUL: result_hi != 0. AND/OR: 0.
- illegal  output  1  the last completed command was an illegal code.

Behaviour:
- Reset (rst=1 at an edge): state goes to IDLE. result, result_hi, zero, overflow, illegal, done and busy all go to 0; ready goes to 1. Reset aborts any multiply in progress, and nothing from that multiply is retained.
- FSM states: IDLE, MULT, DONE.
- IDLE, start=1 at edge k:
  - Operands and command are latched.
  - ADD/SUB/AND/OR/illegal: result and flags are registered at edge k and the state goes to DONE. done=1 in cycle k+1, a latency of 1.
  - MUL: the accumulator is cleared, the counter is set to 0, and the state goes to MULT.
- MULT: each cycle, if multiplier bit 0 = 1, add the multiplicand into the upper half of the 2*WIDTH accumulator. Then shift right by one and increment the counter. After WIDTH iterations the product is written to {result_hi, result} and the state goes to DONE. done=1 in cycle k+WIDTH+1.
- DONE: done=1 for exactly one cycle, then the state returns to IDLE unconditionally.
- start is ignored in MULT and DONE, and there is no queuing. The earliest back-to-back start is the cycle after done.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^WIDTH.
  - Overflow: ADD sets it when the operand signs are equal and the result sign differs. SUB sets it when the operand signs differ and the result sign differs from operand_a.
  - MUL is unsigned WIDTH x WIDTH -> 2*WIDTH.
- Illegal codes 5..15: result=0, result_hi=0, zero=1, overflow=0, illegal=1; completes with latency 1.
- illegal clears on the next legal completion.
- result, result_hi and all flags hold their values from the last completion until the next completion or reset. They are never updated mid-MULT.
- Operand inputs may change after acceptance without affecting the operation in flight.
- Every display statement is wrapped so that synthesis ignores it.

Decomposition:
- Package alu_pkg:
  - Opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_AND=3, OP_OR=4.
  - State encoding for IDLE/MULT/DONE.
  - Default WIDTH.
  - The package is shared with the alu_control decoder so that the opcode values have a single source.
- One sub-module, alu_mul_seq:
  - Contents: the shift-add accumulator and counter.
  - Handshake: takes load/a/b and returns product plus mul_done.
  - The top-level FSM, the single-cycle ops and the flag logic remain in alu_exec_unit.

Test Plan:
- ADD, a=0x7FFFFFFF, b=1 -> done in cycle k+1, result=0x80000000, overflow=1, zero=0.
- SUB, a=5, b=5 -> result=0, zero=1, overflow=0. Then AND a=0xF0F0F0F0, b=0xFF00FF00 -> result=0xF000F000.
- MUL, a=0xFFFFFFFF, b=2 -> busy for 32 cycles, done at cycle k+33, result=0xFFFFFFFE, result_hi=1, overflow=1. Also MUL 6*7 -> result=42, result_hi=0, overflow=0.
- start pulsed with different operands during MULT -> ignored; the product equals the original operands' product. ready=0 throughout MULT and DONE.
- ctrl_command=9 -> done at k+1, result=0, illegal=1. A following OR a=1, b=2 -> result=3, illegal=0.
- rst asserted at cycle 10 of a MUL -> next cycle: IDLE, ready=1, all outputs 0, and no done pulse. A new ADD 2+3 -> result=5.
